// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART blocks.
// The receiver uses the same divisor convention.
package uart_pkg;

    typedef enum logic {
        IDLE,
        XMIT
    } tx_state_t;

    localparam int FRAME_BITS       = 10;
    localparam int DEFAULT_BAUD_DIV = 2604;

endpackage

// File: rtl/uart_tx_buf_if.sv
// uart_tx_buf_if: host-side push/status bundle of the UART transmitter.
// The master is the host, the slave is the transmitter.
interface uart_tx_buf_if;
    import uart_pkg::*;

    logic       trmt;
    logic [7:0] tx_data;
    logic       clr_ovfl;
    logic       busy;
    logic       full;
    logic       tx_done;
    logic       ovfl;

    modport master (
        output trmt,
        output tx_data,
        output clr_ovfl,
        input  busy,
        input  full,
        input  tx_done,
        input  ovfl
    );

    modport slave (
        input  trmt,
        input  tx_data,
        input  clr_ovfl,
        output busy,
        output full,
        output tx_done,
        output ovfl
    );

endinterface

// File: rtl/uart_tx_buf_byte_fifo.sv
// byte_fifo: small power-of-2 byte queue with registered count.
// A pop on the same edge never makes room for a push.
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_push,
    input  logic [7:0] i_data,
    input  logic       i_pop,
    output logic [7:0] o_data,
    output logic       o_full,
    output logic       o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_count;
    logic          w_wr;
    logic          w_rd;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_wr    = i_push & ~o_full;
    assign w_rd    = i_pop & ~o_empty;
    assign o_data  = r_mem[r_rd];

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr] <= i_data;
        end
    end

    // pointers wrap naturally because DEPTH is a power of 2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_rd) begin
                r_rd <= r_rd + 1'b1;
            end
            unique case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buf.sv
// uart_tx_buf: 8N1 transmitter fed by a byte FIFO.
// Queued bytes leave back-to-back with no idle gap.
module uart_tx_buf
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV,
    parameter int DEPTH    = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    uart_tx_buf_if.slave bus,
    output logic         TX
);
    localparam logic [11:0] BAUD_RELOAD = 12'(BAUD_DIV - 1);
    localparam logic [3:0]  LAST_BIT    = 4'(FRAME_BITS - 1);

    tx_state_t   r_state;
    logic [9:0]  r_shift;
    logic [11:0] r_baud;
    logic [3:0]  r_bit;
    logic        r_done;
    logic        r_ovfl;
    logic        w_push;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    logic        w_bit_end;
    logic        w_frame_end;
    logic [7:0]  w_head;

    assign w_push      = bus.trmt & ~w_full;
    assign w_bit_end   = (r_state == XMIT) && (r_baud == '0);
    assign w_frame_end = w_bit_end && (r_bit == LAST_BIT);
    assign w_pop       = ~w_empty
                       & ((r_state == IDLE) | w_frame_end);

    byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (bus.trmt),
        .i_data  (bus.tx_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // shifter idles all-ones, so its LSB is the line
    assign TX          = r_shift[0];
    assign bus.busy    = (r_state == XMIT) | ~w_empty;
    assign bus.full    = w_full;
    assign bus.tx_done = r_done;
    assign bus.ovfl    = r_ovfl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_shift <= '1;
            r_baud  <= '0;
            r_bit   <= '0;
            r_done  <= 1'b0;
            r_ovfl  <= 1'b0;
        end else begin
            if (w_pop) begin
                r_state <= XMIT;
                r_shift <= {1'b1, w_head, 1'b0};
                r_bit   <= '0;
                r_baud  <= BAUD_RELOAD;
            end else if (w_frame_end) begin
                r_state <= IDLE;
                r_shift <= '1;
                r_bit   <= '0;
                r_baud  <= BAUD_RELOAD;
            end else if (w_bit_end) begin
                r_shift <= {1'b1, r_shift[9:1]};
                r_bit   <= r_bit + 1'b1;
                r_baud  <= BAUD_RELOAD;
            end else if (r_state == XMIT) begin
                r_baud  <= r_baud - 1'b1;
            end

            // a push landing on the final stop edge keeps done low
            if (w_push) begin
                r_done <= 1'b0;
            end else if (w_frame_end && w_empty) begin
                r_done <= 1'b1;
            end

            if (bus.trmt && w_full) begin
                r_ovfl <= 1'b1;
            end else if (bus.clr_ovfl) begin
                r_ovfl <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_buf.sv
// tb_uart_tx_buf: directed vectors for the buffered UART transmitter.
// Fast instance at divisor 16, second instance at the default divisor.
module tb_uart_tx_buf;
    import uart_pkg::*;

    localparam int DIV  = 16;
    localparam int DDIV = 2604;

    typedef struct {
        logic [7:0] d;
        logic [9:0] f;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tx_a;
    logic tx_b;
    int   total = 0;
    int   bad = 0;
    int unsigned cyc = 0;
    logic [7:0] rxq[$];

    uart_tx_buf_if ia ();
    uart_tx_buf_if ib ();

    uart_tx_buf #(
        .BAUD_DIV (DIV),
        .DEPTH    (4)
    ) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ia.slave),
        .TX    (tx_a)
    );

    uart_tx_buf dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ib.slave),
        .TX    (tx_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // push one byte, then follow the line cycle by cycle
    task automatic send_check(input string nm, input logic [7:0] d,
                              input logic [9:0] f);
        int errs;
        errs = 0;
        ia.tx_data = d;
        ia.trmt = 1'b1;
        tick();
        ia.trmt = 1'b0;
        chk({nm, "_idle_after_push"}, 32'(tx_a), 32'd1);
        for (int j = 0; j < 10 * DIV; j++) begin
            tick();
            if (tx_a !== f[j / DIV]) errs++;
        end
        chk({nm, "_bits"}, 32'(errs), 32'd0);
        chk({nm, "_done_early"}, 32'(ia.tx_done), 32'd0);
        tick();
        chk({nm, "_done"}, 32'(ia.tx_done), 32'd1);
        chk({nm, "_busy_low"}, 32'(ia.busy), 32'd0);
    endtask

    // line monitor for the fast instance: mid-bit sampling
    initial begin : rx_mon
        logic [7:0] b;
        b = '0;
        forever begin
            tick();
            if (rst_n && tx_a === 1'b0) begin
                repeat (DIV + DIV / 2) tick();
                for (int i = 0; i < 8; i++) begin
                    b[i] = tx_a;
                    if (i < 7) repeat (DIV) tick();
                end
                repeat (DIV) tick();
                if (tx_a === 1'b1) rxq.push_back(b);
            end
        end
    end

    initial begin : stim
        vec_t vt[5];
        int   errs;
        int   fl;
        int unsigned c0;
        logic [29:0] s3;
        logic [9:0]  fb;
        logic [7:0]  rb;

        vt[0] = '{d: 8'hA5, f: 10'h34A};
        vt[1] = '{d: 8'h00, f: 10'h200};
        vt[2] = '{d: 8'hFF, f: 10'h3FE};
        vt[3] = '{d: 8'h3C, f: 10'h278};
        vt[4] = '{d: 8'h81, f: 10'h302};

        ia.trmt = 1'b0; ia.tx_data = '0; ia.clr_ovfl = 1'b0;
        ib.trmt = 1'b0; ib.tx_data = '0; ib.clr_ovfl = 1'b0;

        repeat (2) tick();
        chk("rst_tx", 32'(tx_a), 32'd1);
        chk("rst_busy", 32'(ia.busy), 32'd0);
        chk("rst_full", 32'(ia.full), 32'd0);
        chk("rst_done", 32'(ia.tx_done), 32'd0);
        chk("rst_ovfl", 32'(ia.ovfl), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 5; v++) begin
            send_check($sformatf("vec%0d", v), vt[v].d, vt[v].f);
        end

        // three frames back-to-back
        rxq.delete();
        s3 = {10'h278, 10'h3FE, 10'h200};
        errs = 0;
        fl = 0;
        ia.tx_data = 8'h00; ia.trmt = 1'b1;
        tick();
        ia.tx_data = 8'hFF;
        for (int j = 0; j < 30 * DIV; j++) begin
            tick();
            if (j == 0) ia.tx_data = 8'h3C;
            if (j == 1) ia.trmt = 1'b0;
            if (tx_a !== s3[j / DIV]) errs++;
            if (ia.full !== 1'b0) fl++;
        end
        chk("b2b_stream", 32'(errs), 32'd0);
        chk("b2b_full_never", 32'(fl), 32'd0);
        chk("b2b_done_early", 32'(ia.tx_done), 32'd0);
        tick();
        chk("b2b_done", 32'(ia.tx_done), 32'd1);
        chk("b2b_rx_count", 32'(rxq.size()), 32'd3);
        if (rxq.size() == 3) begin
            chk("b2b_rx2", 32'(rxq[2]), 32'h3C);
        end

        // push on the cycle where done would set
        rxq.delete();
        ia.tx_data = 8'h5A; ia.trmt = 1'b1;
        tick();
        ia.trmt = 1'b0;
        repeat (10 * DIV) tick();
        chk("late_done_before", 32'(ia.tx_done), 32'd0);
        ia.tx_data = 8'hC3; ia.trmt = 1'b1;
        tick();
        ia.trmt = 1'b0;
        chk("late_done_held", 32'(ia.tx_done), 32'd0);
        chk("late_busy", 32'(ia.busy), 32'd1);
        tick();
        chk("late_start", 32'(tx_a), 32'd0);
        for (int n = 0; n < 400 && !ia.tx_done; n++) tick();
        chk("late_done_after", 32'(ia.tx_done), 32'd1);
        chk("late_rx_count", 32'(rxq.size()), 32'd2);
        if (rxq.size() == 2) begin
            chk("late_rx1", 32'(rxq[1]), 32'hC3);
        end

        // overflow: six pushes into a depth-4 queue
        rxq.delete();
        c0 = 0;
        for (int i = 0; i < 6; i++) begin
            ia.tx_data = 8'(8'h11 * (i + 1));
            ia.trmt = 1'b1;
            tick();
            if (i == 0) c0 = cyc;
            if (i == 4) chk("ovf_full", 32'(ia.full), 32'd1);
        end
        chk("ovf_flag", 32'(ia.ovfl), 32'd1);
        ia.clr_ovfl = 1'b1;
        tick();
        ia.trmt = 1'b0;
        ia.clr_ovfl = 1'b0;
        chk("ovf_set_wins", 32'(ia.ovfl), 32'd1);
        for (int n = 0; n < 2000 && !ia.tx_done; n++) tick();
        chk("ovf_len", cyc - c0, 32'd801);
        chk("ovf_rx_count", 32'(rxq.size()), 32'd5);
        if (rxq.size() == 5) begin
            chk("ovf_rx4", 32'(rxq[4]), 32'h55);
        end
        chk("ovf_sticky", 32'(ia.ovfl), 32'd1);
        ia.clr_ovfl = 1'b1;
        tick();
        ia.clr_ovfl = 1'b0;
        chk("ovf_clear", 32'(ia.ovfl), 32'd0);

        // reset during data bit 3 of 0x81 with more bytes queued
        ia.tx_data = 8'h81; ia.trmt = 1'b1;
        tick();
        ia.tx_data = 8'h7E;
        tick();
        ia.trmt = 1'b0;
        repeat (70) tick();
        chk("mid_bit3", 32'(tx_a), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tx", 32'(tx_a), 32'd1);
        chk("mid_rst_busy", 32'(ia.busy), 32'd0);
        chk("mid_rst_full", 32'(ia.full), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        errs = 0;
        for (int n = 0; n < 300; n++) begin
            tick();
            if (tx_a !== 1'b1 || ia.busy !== 1'b0) errs++;
        end
        chk("mid_quiet", 32'(errs), 32'd0);

        // default divisor, 0x55
        fb = 10'h2AA;
        rb = '0;
        errs = 0;
        ib.tx_data = 8'h55; ib.trmt = 1'b1;
        tick();
        ib.trmt = 1'b0;
        chk("def_idle_after_push", 32'(tx_b), 32'd1);
        for (int j = 0; j < 10 * DDIV; j++) begin
            tick();
            if (tx_b !== fb[j / DDIV]) errs++;
            if ((j % DDIV) == DDIV / 2 && j / DDIV >= 1 && j / DDIV <= 8)
                rb[j / DDIV - 1] = tx_b;
        end
        chk("def_cells", 32'(errs), 32'd0);
        chk("def_byte", 32'(rb), 32'h55);
        chk("def_done_early", 32'(ib.tx_done), 32'd0);
        tick();
        chk("def_done", 32'(ib.tx_done), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
